// File: rtl/reg_writeback_arbiter.sv
// Owns the integer register file write port: ALU results win, LSU results drain from a small FIFO.
// ALU latency 1 cycle, LSU >= 2 (1 via bypass when WB_BYPASS_EN); lsu_ready drops when FIFO is full.
module reg_writeback_arbiter #(
    parameter int XLEN       = 64,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alu_valid,
    input  logic [4:0]                        alu_rd,
    input  logic [XLEN-1:0]                   alu_data,
    input  logic                              lsu_valid,
    input  logic [4:0]                        lsu_rd,
    input  logic [XLEN-1:0]                   lsu_data,
    output logic                              lsu_ready,
    input  logic                              issue_valid,
    input  logic [4:0]                        issue_rd,
    output logic                              RegWrite,
    output logic [4:0]                        rd,
    output logic [XLEN-1:0]                   WriteData,
    output logic [NREG-1:0]                   pend_mask,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] dat;
    } wb_ent_t;

    wb_ent_t         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    wb_ent_t         head;
    logic            alu_win;
    logic            pop;
    logic            push;
    logic            bypass;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    assign lsu_ready = (fifo_count != CW'(FIFO_DEPTH));

    always_comb begin
        head    = fifo_mem[rd_ptr];
        alu_win = alu_valid && (alu_rd != 5'd0);
        pop     = !alu_win && (fifo_count != '0);
`ifdef WB_BYPASS_EN
        bypass  = !alu_win && (fifo_count == '0) && lsu_valid;
`else
        bypass  = 1'b0;
`endif
        // a bypassed result never occupies a FIFO slot
        push     = lsu_valid && lsu_ready && !bypass;
        clr_mask = '0;
        set_mask = '0;
        if (pop && head.rd != 5'd0)
            clr_mask[head.rd] = 1'b1;
        if (bypass && lsu_rd != 5'd0)
            clr_mask[lsu_rd] = 1'b1;
        if (issue_valid && issue_rd != 5'd0)
            set_mask[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: lsu_rd, dat: lsu_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite   <= 1'b0;
            rd         <= '0;
            WriteData  <= '0;
            pend_mask  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (alu_win) begin
                RegWrite  <= 1'b1;
                rd        <= alu_rd;
                WriteData <= alu_data;
            end else if (pop) begin
                // an x0 entry is consumed without a write; rd/WriteData keep their last values
                if (head.rd != 5'd0) begin
                    RegWrite  <= 1'b1;
                    rd        <= head.rd;
                    WriteData <= head.dat;
                end
            end else if (bypass) begin
                if (lsu_rd != 5'd0) begin
                    RegWrite  <= 1'b1;
                    rd        <= lsu_rd;
                    WriteData <= lsu_data;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            // set wins over clear for the same register
            pend_mask  <= (pend_mask & ~clr_mask) | set_mask;
        end
    end
endmodule
